alu: RTL and testbench
======================

Name: alu

Overview:
- Registered, signed, two-operand arithmetic/logic unit for the CPU datapath.
- An 8-bit opcode selects the operation on two signed BUS_WIDTH-bit operands.
- The result is captured in an output register, one cycle after the inputs are sampled.
- Opcode 0x0B (move_cpu) passes operand 1 through unchanged so the CPU can do register moves.

Parameters:
- BUS_WIDTH, 4, operand/result width in bits; all data is two's-complement signed.

Ports:
- clock_in  input  1  system clock; all state updates on rising edge.
- reset_in  input  1  synchronous, active-high reset.
- enable_in  input  1  when high, the output register loads a new result; when low, it holds.
- opcode_in  input  8  signed operation select; full 8 bits decoded.
- alu_input1  input  BUS_WIDTH  signed operand A.
- alu_input2  input  BUS_WIDTH  signed operand B.
- alu_output  output  BUS_WIDTH  signed registered result.

Behaviour:
- On a rising clock_in edge with reset_in=1: alu_output <= 0. Reset has priority over enable_in and opcode_in, including mid-operation.
- On a rising edge with reset_in=0 and enable_in=1: alu_output <= f(opcode_in, A, B).
  - Latency is 1 cycle; a new result is accepted every cycle; there is no handshake.
- On a rising edge with reset_in=0 and enable_in=0: alu_output holds its value.
- Opcode map (all results truncated to BUS_WIDTH bits, two's-complement wrap, no saturation):
  - 0x00 ADD: A+B.
  - 0x01 SUB: A-B.
  - 0x02 MUL: low BUS_WIDTH bits of the signed product A*B (see Optional Feature).
  - 0x03 EQ: 1 if A==B, else 0; zero-extended.
  - 0x04 GT: 1 if A>B as signed, else 0; zero-extended.
  - 0x05 AND: A&B.
  - 0x06 OR: A|B.
  - 0x07 XOR: A^B.
  - 0x08 NOT: ~A.
  - 0x09 SHL: A << B[1:0] (logical).
  - 0x0A SHR: A >>> B[1:0] (arithmetic, sign-filling).
  - 0x0B MOV (move_cpu): A. B is ignored.
  - All other opcode values (0x0C-0xFF, including negative encodings): result 0.
- Combinational next-result logic is purely a function of the current inputs; there is no internal state other than the output register.
- Overflow is not flagged. Wrap examples:
  - 7+1 -> -8.
  - -8-1 -> 7.
- Comparisons use the full signed range: GT(-8, 7) = 0; GT(7, -8) = 1.

Optional Feature:
- Macro: ALU_MULTIPLIER_EN.
- Defined: opcode 0x02 performs signed multiply, keeping the low BUS_WIDTH bits.
- Undefined: no multiplier hardware is built, and opcode 0x02 is treated as unsupported (result 0).

Decomposition:
- Package alu_pkg holds:
  - the BUS_WIDTH default constant;
  - a typedef enum logic [7:0] alu_opcode_t with the names ADD, SUB, MUL, EQ, GT, AND, OR, XOR, NOT, SHL, SHR, MOV and the values above.
- One sub-module is natural: alu_multiplier, a combinational signed BUS_WIDTH x BUS_WIDTH multiplier returning the truncated product. It is instantiated only under ALU_MULTIPLIER_EN.
- The remaining logic is a single case-based combinational block feeding the output register.

Test Plan:
- Reset: drive reset_in=1 for one edge with any inputs -> alu_output=0; after release, alu_output remains 0 until the first enabled edge.
- ADD/SUB exhaustive sweep (A, B over -8..7, one edge each):
  - check alu_output == (A+B) and (A-B) truncated to 4 bits;
  - spot checks 7+1 -> -8 and -8-1 -> 7.
- EQ/GT exhaustive sweep:
  - EQ(5,5)=1, EQ(5,-5)=0;
  - GT(-1,-2)=1, GT(-8,7)=0, GT(3,3)=0.
- MOV: opcode 0x0B, A=-5, B=6 -> alu_output=-5; sweep all A/B pairs -> output always equals A.
- MUL (macro defined): 3*-3 -> 7 (low bits of -9); -8*-1 -> -8; with the macro undefined, opcode 0x02 -> 0.
- Enable/unsupported:
  - load ADD 2+3 -> 5, then enable_in=0 and change inputs -> output holds 5 for several cycles;
  - opcode 0x20 with enable_in=1 -> output 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and opcode encoding for the datapath ALU.
// Opcode 0x02 is live only when ALU_MULTIPLIER_EN is defined.
package alu_pkg;

  localparam int ALU_BUS_WIDTH = 4;

  typedef enum logic [7:0] {
    ADD = 8'h00,
    SUB = 8'h01,
    MUL = 8'h02,
    EQ  = 8'h03,
    GT  = 8'h04,
    AND = 8'h05,
    OR  = 8'h06,
    XOR = 8'h07,
    NOT = 8'h08,
    SHL = 8'h09,
    SHR = 8'h0A,
    MOV = 8'h0B
  } alu_opcode_t;

endpackage

// File: rtl/alu_multiplier.sv
// Combinational signed multiplier keeping the low BUS_WIDTH product bits.
// Built by the ALU top only when ALU_MULTIPLIER_EN is defined.
module alu_multiplier
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = ALU_BUS_WIDTH
) (
  input  logic signed [BUS_WIDTH-1:0] a_i,
  input  logic signed [BUS_WIDTH-1:0] b_i,
  output logic signed [BUS_WIDTH-1:0] p_o
);

  // Low bits of a two's-complement product do not depend on sign extension.
  assign p_o = a_i * b_i;

endmodule

// File: rtl/alu.sv
// Registered signed two-operand ALU with one-cycle latency.
// Define ALU_MULTIPLIER_EN to enable opcode 0x02 (signed multiply).
module alu
  import alu_pkg::*;
#(
  parameter int BUS_WIDTH = ALU_BUS_WIDTH
) (
  input  logic                        clock_in,
  input  logic                        reset_in,
  input  logic                        enable_in,
  input  logic signed [7:0]           opcode_in,
  input  logic signed [BUS_WIDTH-1:0] alu_input1,
  input  logic signed [BUS_WIDTH-1:0] alu_input2,
  output logic signed [BUS_WIDTH-1:0] alu_output
);

  localparam logic [BUS_WIDTH-1:0] ZERO = '0;

  logic [7:0]                  op;
  logic [1:0]                  sh;
  logic signed [BUS_WIDTH-1:0] alu_d;
  logic signed [BUS_WIDTH-1:0] alu_q;

  assign op = opcode_in;
  assign sh = alu_input2[1:0];

`ifdef ALU_MULTIPLIER_EN
  logic signed [BUS_WIDTH-1:0] mul_w;

  alu_multiplier #(
    .BUS_WIDTH (BUS_WIDTH)
  ) u_mul (
    .a_i (alu_input1),
    .b_i (alu_input2),
    .p_o (mul_w)
  );
`endif

  always_comb begin
    alu_d = ZERO;
    case (op)
      ADD: alu_d = alu_input1 + alu_input2;
      SUB: alu_d = alu_input1 - alu_input2;
`ifdef ALU_MULTIPLIER_EN
      MUL: alu_d = mul_w;
`endif
      EQ:  alu_d = {ZERO[BUS_WIDTH-1:1],
                    alu_input1 == alu_input2};
      GT:  alu_d = {ZERO[BUS_WIDTH-1:1],
                    alu_input1 > alu_input2};
      AND: alu_d = alu_input1 & alu_input2;
      OR:  alu_d = alu_input1 | alu_input2;
      XOR: alu_d = alu_input1 ^ alu_input2;
      NOT: alu_d = ~alu_input1;
      SHL: alu_d = alu_input1 << sh;
      SHR: alu_d = alu_input1 >>> sh;
      MOV: alu_d = alu_input1;
      default: alu_d = ZERO;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      alu_q <= ZERO;
    end else if (enable_in) begin
      alu_q <= alu_d;
    end
  end

  assign alu_output = alu_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for the registered ALU.
// Honours ALU_MULTIPLIER_EN the same way the design does.
module tb_alu;

  logic              clk;
  logic              rst;
  logic              en;
  logic signed [7:0] op;
  logic signed [3:0] a;
  logic signed [3:0] b;
  logic signed [3:0] y;

  logic [3:0] sb[$];
  logic [3:0] exp_v;
  int         total;
  int         bad;

  alu dut (
    .clock_in   (clk),
    .reset_in   (rst),
    .enable_in  (en),
    .opcode_in  (op),
    .alu_input1 (a),
    .alu_input2 (b),
    .alu_output (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] model(
    input logic [7:0] o, input logic [3:0] x, input logic [3:0] z);
    int ia, ib, r;
    ia = int'($signed(x));
    ib = int'($signed(z));
    r  = 0;
    case (o)
      8'h00: r = ia + ib;
      8'h01: r = ia - ib;
`ifdef ALU_MULTIPLIER_EN
      8'h02: r = ia * ib;
`endif
      8'h03: r = (ia == ib) ? 1 : 0;
      8'h04: r = (ia > ib) ? 1 : 0;
      8'h05: r = int'({28'd0, x & z});
      8'h06: r = int'({28'd0, x | z});
      8'h07: r = int'({28'd0, x ^ z});
      8'h08: r = -ia - 1;
      8'h09: r = ia * (1 << z[1:0]);
      8'h0A: r = ia >>> z[1:0];
      8'h0B: r = ia;
      default: r = 0;
    endcase
    return r[3:0];
  endfunction

  task automatic step(input logic r, input logic e,
    input logic [7:0] o, input logic [3:0] x, input logic [3:0] z);
    @(negedge clk);
    rst = r; en = e; op = o; a = x; b = z;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    sb.push_back(4'd0);
    step(1'b1, 1'b1, 8'h00, 4'd3, 4'd2);
    exp_v = sb.pop_front();
    total++;
    if (y !== exp_v) begin
      bad++;
      $display("FAIL reset got=%h exp=%h", y, exp_v);
    end
    for (int k = 0; k < 2; k++) begin
      sb.push_back(4'd0);
      step(1'b0, 1'b0, 8'h00, 4'd6, 4'd1);
      exp_v = sb.pop_front();
      total++;
      if (y !== exp_v) begin
        bad++;
        $display("FAIL reset_hold k=%0d got=%h exp=%h", k, y, exp_v);
      end
    end
  endtask

  task automatic test_sweep(input logic [7:0] o, input string nm);
    for (int i = -8; i < 8; i++) begin
      for (int j = -8; j < 8; j++) begin
        sb.push_back(model(o, i[3:0], j[3:0]));
        step(1'b0, 1'b1, o, i[3:0], j[3:0]);
        exp_v = sb.pop_front();
        total++;
        if (y !== exp_v) begin
          bad++;
          $display("FAIL %s a=%0d b=%0d got=%0d exp=%0d",
                   nm, i, j, y, $signed(exp_v));
        end
      end
    end
  endtask

  task automatic test_spot;
    logic [7:0] so[13];
    logic [3:0] sa[13];
    logic [3:0] sbv[13];
    logic [3:0] se[13];
    so = '{8'h00, 8'h01, 8'h03, 8'h03, 8'h04, 8'h04, 8'h04,
           8'h04, 8'h0B, 8'h09, 8'h0A, 8'h08, 8'h05};
    sa = '{4'h7, 4'h8, 4'h5, 4'h5, 4'hF, 4'h8, 4'h3,
           4'h7, 4'hB, 4'h3, 4'h8, 4'h5, 4'hC};
    sbv = '{4'h1, 4'h1, 4'h5, 4'hB, 4'hE, 4'h7, 4'h3,
            4'h8, 4'h6, 4'h2, 4'h2, 4'h0, 4'h6};
    se = '{4'h8, 4'h7, 4'h1, 4'h0, 4'h1, 4'h0, 4'h0,
           4'h1, 4'hB, 4'hC, 4'hE, 4'hA, 4'h4};
    for (int k = 0; k < 13; k++) begin
      sb.push_back(se[k]);
      step(1'b0, 1'b1, so[k], sa[k], sbv[k]);
      exp_v = sb.pop_front();
      total++;
      if (y !== exp_v) begin
        bad++;
        $display("FAIL spot k=%0d op=%h got=%h exp=%h",
                 k, so[k], y, exp_v);
      end
    end
  endtask

  task automatic test_mul;
`ifdef ALU_MULTIPLIER_EN
    logic [3:0] e0 = 4'h7;
    logic [3:0] e1 = 4'h8;
`else
    logic [3:0] e0 = 4'h0;
    logic [3:0] e1 = 4'h0;
`endif
    sb.push_back(e0);
    step(1'b0, 1'b1, 8'h02, 4'h3, 4'hD);
    exp_v = sb.pop_front();
    total++;
    if (y !== exp_v) begin
      bad++;
      $display("FAIL mul3xm3 got=%h exp=%h", y, exp_v);
    end
    sb.push_back(e1);
    step(1'b0, 1'b1, 8'h02, 4'h8, 4'hF);
    exp_v = sb.pop_front();
    total++;
    if (y !== exp_v) begin
      bad++;
      $display("FAIL mulm8xm1 got=%h exp=%h", y, exp_v);
    end
  endtask

  task automatic test_enable;
    sb.push_back(4'd5);
    step(1'b0, 1'b1, 8'h00, 4'd2, 4'd3);
    exp_v = sb.pop_front();
    total++;
    if (y !== exp_v) begin
      bad++;
      $display("FAIL en_load got=%h exp=%h", y, exp_v);
    end
    for (int k = 0; k < 4; k++) begin
      sb.push_back(4'd5);
      step(1'b0, 1'b0, 8'h07, 4'(k + 1), 4'hA);
      exp_v = sb.pop_front();
      total++;
      if (y !== exp_v) begin
        bad++;
        $display("FAIL en_hold k=%0d got=%h exp=%h", k, y, exp_v);
      end
    end
  endtask

  task automatic test_unsupported;
    logic [7:0] uo[4];
    uo = '{8'h20, 8'h0C, 8'hFF, 8'h80};
    for (int k = 0; k < 4; k++) begin
      sb.push_back(4'd6);
      step(1'b0, 1'b1, 8'h0B, 4'd6, 4'd0);
      exp_v = sb.pop_front();
      total++;
      if (y !== exp_v) begin
        bad++;
        $display("FAIL unsup_pre k=%0d got=%h exp=%h", k, y, exp_v);
      end
      sb.push_back(4'd0);
      step(1'b0, 1'b1, uo[k], 4'd6, 4'd1);
      exp_v = sb.pop_front();
      total++;
      if (y !== exp_v) begin
        bad++;
        $display("FAIL unsup op=%h got=%h exp=%h", uo[k], y, exp_v);
      end
    end
  endtask

  task automatic test_reset_priority;
    sb.push_back(4'd0);
    step(1'b1, 1'b1, 8'h0B, 4'd7, 4'd0);
    exp_v = sb.pop_front();
    total++;
    if (y !== exp_v) begin
      bad++;
      $display("FAIL rst_prio got=%h exp=%h", y, exp_v);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; en = 1'b0; op = '0; a = '0; b = '0;
    test_reset();
    test_sweep(8'h00, "add");
    test_sweep(8'h01, "sub");
    test_sweep(8'h03, "eq");
    test_sweep(8'h04, "gt");
    test_sweep(8'h0B, "mov");
    test_sweep(8'h05, "and");
    test_sweep(8'h06, "or");
    test_sweep(8'h07, "xor");
    test_sweep(8'h08, "not");
    test_sweep(8'h09, "shl");
    test_sweep(8'h0A, "shr");
    test_sweep(8'h02, "mul");
    test_spot();
    test_mul();
    test_enable();
    test_unsupported();
    test_reset_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
